// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and instruction-memory FSM encoding
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } imem_state_e;

endpackage

// File: rtl/inst_mem_ram.sv
// rtl/inst_mem_ram.sv - single-clock simple dual-port array, registered read-first output
module inst_mem_ram #(
    parameter int              W       = 32,
    parameter int              ADDR_W  = 6,
    parameter int              DEPTH   = 64,
    parameter logic [W-1:0]    CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    input  logic              rclr,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register doubles as the fetch register: rclr loads the NOP, re loads
    // the array (old contents on a same-address write), otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= CLR_VAL;
        end else if (rclr) begin
            rdata <= CLR_VAL;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem_sync.sv
// rtl/inst_mem_sync.sv - writable synchronous instruction memory; optional INST_MEM_PARITY_EN
module inst_mem_sync
    import cpu_pkg::*;
#(
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter int                 ADDR_W   = ADDR_W_DEF,
    parameter int                 DEPTH    = 64,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              addr_err,
    output logic              ready,
`ifdef INST_MEM_PARITY_EN
    output logic              par_err,
`endif
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

`ifdef INST_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
    // Even parity: the stored parity bit makes the XOR of the whole word zero.
    localparam logic [MEM_W-1:0] NOP_MEM = {^NOP_WORD, NOP_WORD};
`else
    localparam int MEM_W = DATA_W;
    localparam logic [MEM_W-1:0] NOP_MEM = NOP_WORD;
`endif

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    imem_state_e       state, state_n;
    logic [ADDR_W-1:0] clr_cnt;
    logic              valid_n, err_n;

    logic              ram_we, ram_re, ram_rclr;
    logic [ADDR_W-1:0] ram_waddr;
    logic [MEM_W-1:0]  ram_wdata, ram_rdata, prog_word;

    logic fetch_in_range, prog_in_range;

    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_L;
    assign prog_in_range  = {1'b0, prog_addr}  < DEPTH_L;

`ifdef INST_MEM_PARITY_EN
    assign prog_word = {^prog_data, prog_data};
`else
    assign prog_word = prog_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            inst_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            state      <= state_n;
            inst_valid <= valid_n;
            addr_err   <= err_n;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        valid_n   = inst_valid;
        err_n     = addr_err;
        ram_we    = 1'b0;
        ram_waddr = prog_addr;
        ram_wdata = prog_word;
        ram_re    = 1'b0;
        ram_rclr  = 1'b0;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = NOP_MEM;
                if (clr_cnt == CLR_LAST) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                ram_we = prog_we && prog_in_range;
                if (flush) begin
                    ram_rclr = 1'b1;
                    valid_n  = 1'b0;
                    err_n    = 1'b0;
                end else if (stall) begin
                    valid_n = inst_valid;
                end else if (fetch_req && fetch_in_range) begin
                    ram_re  = 1'b1;
                    valid_n = 1'b1;
                    err_n   = 1'b0;
                end else if (fetch_req) begin
                    ram_rclr = 1'b1;
                    valid_n  = 1'b1;
                    err_n    = 1'b1;
                end else begin
                    valid_n = 1'b0;
                end
            end
            default: state_n = ST_CLEAR;
        endcase
    end

    inst_mem_ram #(
        .W       (MEM_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .CLR_VAL (NOP_MEM)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rclr  (ram_rclr),
        .raddr (fetch_addr),
        .rdata (ram_rdata)
    );

    assign inst  = ram_rdata[DATA_W-1:0];
    assign ready = (state == ST_RUN);

`ifdef INST_MEM_PARITY_EN
    // Checked on the registered word, so it changes exactly when inst does.
    assign par_err = ^ram_rdata;
`endif

endmodule

// File: tb/tb_inst_mem_sync.sv
// tb/tb_inst_mem_sync.sv - directed self-checking bench for inst_mem_sync (DEPTH 64 and 48)
`timescale 1ns/1ps
module tb_inst_mem_sync;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, stall, flush, prog_we;
    logic [5:0]  fetch_addr, prog_addr;
    logic [31:0] prog_data;

    logic [31:0] inst_a, inst_b;
    logic        valid_a, valid_b, err_a, err_b, ready_a, ready_b;
`ifdef INST_MEM_PARITY_EN
    logic        par_a, par_b;
`endif

    logic [31:0] model_a [64];
    logic [31:0] model_b [48];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inst_mem_sync #(.DATA_W(32), .ADDR_W(6), .DEPTH(64), .NOP_WORD(32'h0)) dut_a (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .stall(stall), .flush(flush), .inst(inst_a), .inst_valid(valid_a),
        .addr_err(err_a), .ready(ready_a),
`ifdef INST_MEM_PARITY_EN
        .par_err(par_a),
`endif
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    inst_mem_sync #(.DATA_W(32), .ADDR_W(6), .DEPTH(48), .NOP_WORD(32'h0)) dut_b (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .stall(stall), .flush(flush), .inst(inst_b), .inst_valid(valid_b),
        .addr_err(err_b), .ready(ready_b),
`ifdef INST_MEM_PARITY_EN
        .par_err(par_b),
`endif
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 64; i++) model_a[i] = 32'h0;
        for (int i = 0; i < 48; i++) model_b[i] = 32'h0;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [31:0] d);
        model_a[a] = d;
        if (a < 6'd48) model_b[a] = d;
    endtask

    task automatic prog(input logic [5:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic wait_ready();
        int ea = 0;
        int eb = 0;
        check("reset_ready_a", 32'(ready_a), 32'd0);
        check("reset_valid_a", 32'(valid_a), 32'd0);
        check("reset_err_b",   32'(err_b),   32'd0);
        check("reset_inst_a",  inst_a,       32'h0);
        for (int e = 1; e <= 200; e++) begin
            step();
            if (ready_a && ea == 0) ea = e;
            if (ready_b && eb == 0) eb = e;
            if (!ready_a) check("clear_valid_a", 32'(valid_a), 32'd0);
            if (ea != 0 && eb != 0) break;
        end
        check("ready_cycles_a", 32'(ea), 32'd64);
        check("ready_cycles_b", 32'(eb), 32'd48);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 64; a++) begin
            fetch_req = 1'b1; fetch_addr = 6'(a);
            step();
            check({tag, "_inst_a"},  inst_a,  model_a[a]);
            check({tag, "_valid_a"}, 32'(valid_a), 32'd1);
            check({tag, "_err_a"},   32'(err_a),   32'd0);
            check({tag, "_valid_b"}, 32'(valid_b), 32'd1);
            if (a < 48) begin
                check({tag, "_inst_b"}, inst_b,      model_b[a]);
                check({tag, "_err_b"},  32'(err_b),  32'd0);
            end else begin
                check({tag, "_oor_inst_b"}, inst_b,     32'h0);
                check({tag, "_oor_err_b"},  32'(err_b), 32'd1);
            end
        end
        fetch_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0; flush = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        clear_models();
        step(); step();
        rst_n = 1'b1;

        // Clear duration and all-NOP contents.
        wait_ready();
        sweep("clear");

        // Load and back-to-back fetch.
        prog(6'h01, 32'h38000866);
        prog(6'h02, 32'h34000481);
        fetch_req = 1'b1; fetch_addr = 6'h01;
        step();
        check("fetch1_inst",  inst_a, 32'h38000866);
        check("fetch1_valid", 32'(valid_a), 32'd1);
        fetch_addr = 6'h02;
        step();
        check("fetch2_inst",  inst_a, 32'h34000481);
        check("fetch2_valid", 32'(valid_a), 32'd1);

        // Stall holds, flush beats stall.
        fetch_req = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_inst",  inst_a, 32'h34000481);
            check("stall_valid", 32'(valid_a), 32'd1);
        end
        flush = 1'b1;
        step();
        check("flush_inst",  inst_a, 32'h0);
        check("flush_valid", 32'(valid_a), 32'd0);
        stall = 1'b0; fetch_req = 1'b1; fetch_addr = 6'h02;
        step();
        check("flush_fetch_inst",  inst_a, 32'h0);
        check("flush_fetch_valid", 32'(valid_a), 32'd0);
        flush = 1'b0;
        step();
        check("refetch_inst", inst_a, 32'h34000481);
        fetch_req = 1'b0;
        step();
        check("idle_valid", 32'(valid_a), 32'd0);
        check("idle_inst",  inst_a, 32'h34000481);

        // Out of range on the 48-word instance.
        fetch_req = 1'b1; fetch_addr = 6'h30;
        step();
        check("oor_inst_b",  inst_b, 32'h0);
        check("oor_valid_b", 32'(valid_b), 32'd1);
        check("oor_err_b",   32'(err_b), 32'd1);
        check("inr_err_a",   32'(err_a), 32'd0);
        fetch_addr = 6'h01;
        step();
        check("err_clear_b", 32'(err_b), 32'd0);
        check("after_oor_b", inst_b, 32'h38000866);
        fetch_req = 1'b0;
        prog(6'h30, 32'hCAFEF00D);
        prog(6'h2F, 32'h12345678);
        sweep("oor_write");

        // Read-first collision.
        prog_we = 1'b1; prog_addr = 6'h05; prog_data = 32'hDEADBEEF;
        fetch_req = 1'b1; fetch_addr = 6'h05;
        step();
        check("collide_old", inst_a, model_a[5]);
        prog_we = 1'b0;
        model_write(6'h05, 32'hDEADBEEF);
        step();
        check("collide_new", inst_a, 32'hDEADBEEF);
        check("collide_new_b", inst_b, 32'hDEADBEEF);
        fetch_req = 1'b0;

`ifdef INST_MEM_PARITY_EN
        check("par_ok", 32'(par_a), 32'd0);
        dut_a.u_ram.mem[1][0] = ~dut_a.u_ram.mem[1][0];
        fetch_req = 1'b1; fetch_addr = 6'h01;
        step();
        check("par_err",   32'(par_a), 32'd1);
        check("par_valid", 32'(valid_a), 32'd1);
        fetch_addr = 6'h02;
        step();
        check("par_clean", 32'(par_a), 32'd0);
        fetch_req = 1'b0;
`endif

        // Reset in the middle of clearing restarts the clear.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("midclear_ready", 32'(ready_a), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_models();
        wait_ready();
        fetch_req = 1'b1; fetch_addr = 6'h05;
        step();
        check("recleared_5", inst_a, 32'h0);
        fetch_addr = 6'h2F;
        step();
        check("recleared_2f_b", inst_b, 32'h0);
        fetch_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
